scene_reg_loader: RTL

- Upstream of the pixel rasterization core: a byte-stream command decoder that fills a shadow copy of the scene state (polygon vertices, polygon colours, enable mask, background colour).
- The shadow copy is promoted atomically to an active copy at a frame boundary, so the rasterizer never sees a half-written scene.
- Active outputs drive the rasterizer's packed polygon, enable and background inputs directly.

---
 rtl/scene_reg_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/scene_reg_loader.sv
// -----------------------------------------------------------------------------
// scene_reg_loader
//
// Byte-stream command decoder that fills a shadow copy of the rasterizer scene
// (per-polygon vertices and colours, enable mask, background colour) and
// promotes it to the active copy in a single edge at a frame boundary, so the
// rasterizer never observes a half-written scene.
//
// Header byte: [7:6] opcode, [5:4] polygon index, [3:0] ignored.
//   00 WRITE_POLY  7 payload bytes: colour, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y
//   01 SET_EN      1 payload byte:  enable mask
//   10 SET_BG      1 payload byte:  background colour
//   11 COMMIT      no payload; swap shadow -> active at the next frame_start
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_valid  command/payload byte and its qualifier
//   in_ready          byte accepted on in_valid && in_ready (from state only)
//   frame_start       one-cycle pulse at row 0, column 0
//   commit_pending    COMMIT accepted, swap not yet done
//   swap_done         one-cycle pulse in the cycle after the active update
//   cmp_en, background_color, poly_color, v{0,1,2}_{x,y}
//                     active scene, polygon i at [W*i +: W] of each bus
// -----------------------------------------------------------------------------
module scene_reg_loader #(
  parameter int N_POLY = 4,
  parameter int WPX    = 7,
  parameter int WPY    = 6,
  parameter int WCOLOR = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     frame_start,
  output logic                     commit_pending,
  output logic                     swap_done,
  output logic [N_POLY-1:0]        cmp_en,
  output logic [WCOLOR-1:0]        background_color,
  output logic [WCOLOR*N_POLY-1:0] poly_color,
  output logic [WPX*N_POLY-1:0]    v0_x,
  output logic [WPX*N_POLY-1:0]    v1_x,
  output logic [WPX*N_POLY-1:0]    v2_x,
  output logic [WPY*N_POLY-1:0]    v0_y,
  output logic [WPY*N_POLY-1:0]    v1_y,
  output logic [WPY*N_POLY-1:0]    v2_y
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_FRAME} state_e;
  typedef enum logic [1:0] {OP_WRITE, OP_EN, OP_BG, OP_COMMIT} opcode_e;

  // Packed 2-D fields: element i of each array lands at [W*i +: W], which is
  // exactly the rasterizer's packed bus layout.
  typedef struct packed {
    logic [N_POLY-1:0]             en;
    logic [WCOLOR-1:0]             bg;
    logic [N_POLY-1:0][WCOLOR-1:0] color;
    logic [N_POLY-1:0][WPX-1:0]    v0x;
    logic [N_POLY-1:0][WPY-1:0]    v0y;
    logic [N_POLY-1:0][WPX-1:0]    v1x;
    logic [N_POLY-1:0][WPY-1:0]    v1y;
    logic [N_POLY-1:0][WPX-1:0]    v2x;
    logic [N_POLY-1:0][WPY-1:0]    v2y;
  } scene_t;

  state_e     state_q, state_d;
  opcode_e    op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;     // payload bytes still expected
  scene_t     shd_q, shd_d;     // shadow copy, written by the byte stream
  scene_t     act_q, act_d;     // active copy, seen by the rasterizer
  logic       swap_q, swap_d;

  logic    accept;
  opcode_e hdr_op;

  assign in_ready = (state_q != WAIT_FRAME);
  assign accept   = in_valid && in_ready;
  assign hdr_op   = opcode_e'(in_data[7:6]);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shd_d   = shd_q;
    act_d   = act_q;
    swap_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = hdr_op;
          idx_d = in_data[5:4];
          unique case (hdr_op)
            OP_WRITE: begin state_d = PAYLOAD; cnt_d = 3'd7; end
            OP_EN,
            OP_BG:    begin state_d = PAYLOAD; cnt_d = 3'd1; end
            OP_COMMIT: begin
              // A coincident frame_start swaps on this very edge.
              if (frame_start) begin
                act_d  = shd_q;
                swap_d = 1'b1;
              end else begin
                state_d = WAIT_FRAME;
              end
            end
          endcase
        end
      end

      PAYLOAD: begin
        if (accept) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
          unique case (op_q)
            OP_WRITE: begin
              // An index with no matching polygon consumes bytes, writes nothing.
              for (int i = 0; i < N_POLY; i++) begin
                if (idx_q == 2'(i)) begin
                  case (cnt_q)
                    3'd7:    shd_d.color[i] = in_data[WCOLOR-1:0];
                    3'd6:    shd_d.v0x[i]   = in_data[WPX-1:0];
                    3'd5:    shd_d.v0y[i]   = in_data[WPY-1:0];
                    3'd4:    shd_d.v1x[i]   = in_data[WPX-1:0];
                    3'd3:    shd_d.v1y[i]   = in_data[WPY-1:0];
                    3'd2:    shd_d.v2x[i]   = in_data[WPX-1:0];
                    3'd1:    shd_d.v2y[i]   = in_data[WPY-1:0];
                    default: ;
                  endcase
                end
              end
            end
            OP_EN:   shd_d.en = in_data[N_POLY-1:0];
            OP_BG:   shd_d.bg = in_data[WCOLOR-1:0];
            default: ;
          endcase
        end
      end

      WAIT_FRAME: begin
        if (frame_start) begin
          act_d   = shd_q;
          swap_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset clears both scene copies too; the rasterizer must see a blank
  // scene out of reset, not whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_WRITE;
      idx_q   <= '0;
      cnt_q   <= '0;
      shd_q   <= '0;
      act_q   <= '0;
      swap_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shd_q   <= shd_d;
      act_q   <= act_d;
      swap_q  <= swap_d;
    end
  end

  assign commit_pending   = (state_q == WAIT_FRAME);
  assign swap_done        = swap_q;
  assign cmp_en           = act_q.en;
  assign background_color = act_q.bg;
  assign poly_color       = act_q.color;
  assign v0_x             = act_q.v0x;
  assign v0_y             = act_q.v0y;
  assign v1_x             = act_q.v1x;
  assign v1_y             = act_q.v1y;
  assign v2_x             = act_q.v2x;
  assign v2_y             = act_q.v2y;

endmodule
